// File: rtl/phy_mgmt_ctrl.sv
`timescale 1ns/1ps
// phy_mgmt_ctrl
// PHY management controller: holds the PHY in hard reset after system reset,
// then runs Clause 22 MDIO frames, either for host commands or for
// autonomous link-status polls.
//
// Ports
//   clk_sys, rst_n_sys     system clock, asynchronous active-low reset
//   phy_reset_n            PHY hard reset (active-low)
//   mdc                    management clock, 2*CLK_DIV clk_sys cycles per bit
//   mdio_o, mdio_oe        MDIO drive value and output enable
//   mdio_i                 MDIO value, sampled in the cycle mdc rises
//   cmd_valid/cmd_ready    host command handshake (cmd_write, cmd_phyad,
//                          cmd_regad, cmd_wdata)
//   rsp_valid, rsp_rdata   one-cycle completion pulse and read data
//   poll_en                enables the periodic link poll
//   link_up, link_speed    last poll result (status bit 10, bits 15:14)
//   busy                   high in every state except IDLE
//   dbg_state              current FSM state
//
// Handshake: a command transfers on a rising clk_sys edge where
// cmd_valid && cmd_ready. cmd_ready is high only in IDLE and does not
// depend on cmd_valid; all cmd_* fields are captured on that edge. A
// valid command may be held across busy periods and is taken the next
// IDLE cycle. rsp_valid is a single-cycle pulse with no back-pressure.
module phy_mgmt_ctrl #(
  parameter int         CLK_DIV      = 25,
  parameter int         RESET_CYCLES = 100,
  parameter int         POLL_CYCLES  = 1000000,
  parameter logic [4:0] PHY_ADDR     = 5'd0,
  parameter logic [4:0] POLL_REG     = 5'd17
) (
  input  logic        clk_sys,
  input  logic        rst_n_sys,
  output logic        phy_reset_n,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_phyad,
  input  logic [4:0]  cmd_regad,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  input  logic        poll_en,
  output logic        link_up,
  output logic [1:0]  link_speed,
  output logic        busy,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    RST_HOLD = 3'd0,
    IDLE     = 3'd1,
    PRE      = 3'd2,
    CMD      = 3'd3,
    TA       = 3'd4,
    DATA     = 3'd5,
    DONE     = 3'd6
  } state_t;

  localparam int DIV_W = $clog2(2 * CLK_DIV);
  localparam int RST_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(CLK_DIV);
  localparam logic [RST_W-1:0] RST_LAST  = RST_W'(RESET_CYCLES - 1);
  localparam logic [31:0]      POLL_LAST = 32'(POLL_CYCLES - 1);

  state_t             state, state_n;
  logic [DIV_W-1:0]   div_cnt;
  logic [4:0]         bit_cnt;
  logic [RST_W-1:0]   rst_cnt;
  logic [31:0]        poll_cnt;
  logic               poll_pending;
  logic               op_write;
  logic               op_poll;
  logic [4:0]         op_phyad;
  logic [4:0]         op_regad;
  logic [15:0]        op_wdata;
  logic [15:0]        rd_shift;

  logic               in_frame;
  logic               bit_end;
  logic               mdc_rise;
  logic               start_host;
  logic               start_poll;
  logic               poll_hit;
  logic [13:0]        cmd_bits;
  logic [3:0]         cmd_idx;
  logic [3:0]         data_idx;

  assign in_frame = (state == PRE) || (state == CMD) || (state == TA) || (state == DATA);
  assign bit_end  = (div_cnt == DIV_LAST);
  assign mdc_rise = (div_cnt == DIV_HALF);
  assign poll_hit = poll_en && (poll_cnt == POLL_LAST);

  // ST=01, OP=01 write / 10 read, then PHYAD and REGAD, sent MSB first.
  assign cmd_bits = {2'b01, (op_write ? 2'b01 : 2'b10), op_phyad, op_regad};
  assign cmd_idx  = 4'd13 - bit_cnt[3:0];
  assign data_idx = 4'd15 - bit_cnt[3:0];

  // Next-state logic
  always_comb begin
    state_n    = state;
    start_host = 1'b0;
    start_poll = 1'b0;
    case (state)
      RST_HOLD: if (rst_cnt == RST_LAST) state_n = IDLE;
      IDLE: begin
        // Host commands win; a deferred poll stays pending.
        if (cmd_valid) begin
          start_host = 1'b1;
          state_n    = PRE;
        end else if (poll_pending) begin
          start_poll = 1'b1;
          state_n    = PRE;
        end
      end
      PRE:  if (bit_end && (bit_cnt == 5'd31)) state_n = CMD;
      CMD:  if (bit_end && (bit_cnt == 5'd13)) state_n = TA;
      TA:   if (bit_end && (bit_cnt == 5'd1))  state_n = DATA;
      DATA: if (bit_end && (bit_cnt == 5'd15)) state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = RST_HOLD;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n_sys) begin
    if (!rst_n_sys) begin
      state <= RST_HOLD;
    end else begin
      state <= state_n;
    end
  end

  // Reset-hold, bit-phase and bit counters
  always_ff @(posedge clk_sys or negedge rst_n_sys) begin
    if (!rst_n_sys) begin
      rst_cnt <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      if (state == RST_HOLD) rst_cnt <= rst_cnt + RST_W'(1);
      else                   rst_cnt <= '0;

      if (in_frame) begin
        div_cnt <= bit_end ? '0 : div_cnt + DIV_W'(1);
        if (bit_end) begin
          // Each field restarts its own bit count; counters never wrap.
          bit_cnt <= (state_n != state) ? 5'd0 : bit_cnt + 5'd1;
        end
      end else begin
        div_cnt <= '0;
        bit_cnt <= '0;
      end
    end
  end

  // Poll interval timer. A new interval expiry wins over the clear that
  // happens when a pending poll starts in the same cycle.
  always_ff @(posedge clk_sys or negedge rst_n_sys) begin
    if (!rst_n_sys) begin
      poll_cnt     <= '0;
      poll_pending <= 1'b0;
    end else if (!poll_en) begin
      poll_cnt     <= '0;
      poll_pending <= 1'b0;
    end else begin
      poll_cnt <= poll_hit ? 32'd0 : poll_cnt + 32'd1;
      if (poll_hit)        poll_pending <= 1'b1;
      else if (start_poll) poll_pending <= 1'b0;
    end
  end

  // Transaction capture, read shift register and results
  always_ff @(posedge clk_sys or negedge rst_n_sys) begin
    if (!rst_n_sys) begin
      op_write   <= 1'b0;
      op_poll    <= 1'b0;
      op_phyad   <= '0;
      op_regad   <= '0;
      op_wdata   <= '0;
      rd_shift   <= '0;
      rsp_rdata  <= '0;
      link_up    <= 1'b0;
      link_speed <= 2'b00;
    end else begin
      if (start_host) begin
        op_write <= cmd_write;
        op_poll  <= 1'b0;
        op_phyad <= cmd_phyad;
        op_regad <= cmd_regad;
        op_wdata <= cmd_wdata;
      end else if (start_poll) begin
        op_write <= 1'b0;
        op_poll  <= 1'b1;
        op_phyad <= PHY_ADDR;
        op_regad <= POLL_REG;
        op_wdata <= '0;
      end

      if ((state == DATA) && mdc_rise) rd_shift <= {rd_shift[14:0], mdio_i};

      // Results become visible in DONE, alongside rsp_valid.
      if ((state == DATA) && (state_n == DONE)) begin
        if (op_poll) begin
          link_up    <= rd_shift[10];
          link_speed <= rd_shift[15:14];
        end else if (!op_write) begin
          rsp_rdata <= rd_shift;
        end
      end
    end
  end

  // MDIO drive. Values depend only on state and bit_cnt, which change at
  // bit boundaries, i.e. when mdc falls.
  always_comb begin
    mdio_o  = 1'b1;
    mdio_oe = 1'b0;
    case (state)
      PRE: begin
        mdio_oe = 1'b1;
        mdio_o  = 1'b1;
      end
      CMD: begin
        mdio_oe = 1'b1;
        mdio_o  = cmd_bits[cmd_idx];
      end
      TA: begin
        mdio_oe = op_write;
        mdio_o  = op_write ? ~bit_cnt[0] : 1'b1;
      end
      DATA: begin
        mdio_oe = op_write;
        mdio_o  = op_write ? op_wdata[data_idx] : 1'b1;
      end
      default: begin
        mdio_o  = 1'b1;
        mdio_oe = 1'b0;
      end
    endcase
  end

  assign mdc         = in_frame && (div_cnt >= DIV_HALF);
  assign phy_reset_n = (state != RST_HOLD);
  assign cmd_ready   = (state == IDLE);
  assign busy        = (state != IDLE);
  assign rsp_valid   = (state == DONE) && !op_poll;
  assign dbg_state   = state;

endmodule

// File: tb/tb_phy_mgmt_ctrl.sv
`timescale 1ns/1ps
module tb_phy_mgmt_ctrl;

  localparam int         CD        = 2;
  localparam int         RC        = 100;
  localparam int         PC        = 200;
  localparam logic [4:0] PA        = 5'd3;
  localparam logic [4:0] PR        = 5'd17;
  localparam int         BIT_CYC   = 2 * CD;
  localparam int         FRAME_CYC = 64 * BIT_CYC;

  localparam int P_HOLD  = 0;
  localparam int P_IDLE  = 1;
  localparam int P_FRAME = 2;
  localparam int P_DONE  = 3;

  // ---------------- clock / reset ----------------
  logic clk_sys = 1'b0;
  logic rst_n_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic        phy_reset_n, mdc, mdio_o, mdio_oe;
  logic        mdio_i = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [4:0]  cmd_phyad = '0;
  logic [4:0]  cmd_regad = '0;
  logic [15:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        poll_en = 1'b0;
  logic        link_up;
  logic [1:0]  link_speed;
  logic        busy;
  logic [2:0]  dbg_state;

  phy_mgmt_ctrl #(
    .CLK_DIV(CD), .RESET_CYCLES(RC), .POLL_CYCLES(PC),
    .PHY_ADDR(PA), .POLL_REG(PR)
  ) dut (
    .clk_sys(clk_sys), .rst_n_sys(rst_n_sys),
    .phy_reset_n(phy_reset_n), .mdc(mdc), .mdio_o(mdio_o), .mdio_oe(mdio_oe),
    .mdio_i(mdio_i),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_phyad(cmd_phyad), .cmd_regad(cmd_regad), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .poll_en(poll_en),
    .link_up(link_up), .link_speed(link_speed), .busy(busy),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A frame is a 64-bit vector plus a 64-bit drive-enable vector; a single
  // cycle counter m_t walks through it, BIT_CYC cycles per bit.
  logic [15:0] host_phy_val = 16'h0000;
  logic [15:0] poll_phy_val = 16'h0000;

  int          m_phase = P_HOLD;
  int          m_cyc   = 0;
  int          m_t     = 0;
  logic [63:0] m_frame = '1;
  logic [63:0] m_oe    = '0;
  logic        m_poll  = 1'b0;
  logic        m_write = 1'b0;
  logic [15:0] m_resp  = '0;
  int          m_pcnt  = 0;
  logic        m_pend  = 1'b0;
  logic [15:0] m_rdata = '0;
  logic        m_link  = 1'b0;
  logic [1:0]  m_speed = 2'b00;
  logic        m_hit;
  logic        m_started_poll;

  task automatic model_start(input logic w, input logic [4:0] pa, input logic [4:0] ra,
                             input logic [15:0] wd, input logic is_poll);
    m_frame = {32'hFFFF_FFFF, 2'b01, (w ? 2'b01 : 2'b10), pa, ra,
               (w ? 2'b10 : 2'b11), (w ? wd : 16'hFFFF)};
    m_oe    = w ? {64{1'b1}} : {{46{1'b1}}, {18{1'b0}}};
    m_write = w;
    m_poll  = is_poll;
    m_resp  = is_poll ? poll_phy_val : host_phy_val;
    m_t     = 0;
    m_phase = P_FRAME;
  endtask

  always @(posedge clk_sys or negedge rst_n_sys) begin
    if (!rst_n_sys) begin
      m_phase = P_HOLD; m_cyc = 0; m_t = 0; m_poll = 1'b0; m_write = 1'b0;
      m_pcnt = 0; m_pend = 1'b0; m_rdata = '0; m_link = 1'b0; m_speed = 2'b00;
    end else begin
      m_hit = poll_en && (m_pcnt == PC - 1);
      m_started_poll = 1'b0;
      case (m_phase)
        P_HOLD: begin
          m_cyc++;
          if (m_cyc == RC) m_phase = P_IDLE;
        end
        P_IDLE: begin
          if (cmd_valid) model_start(cmd_write, cmd_phyad, cmd_regad, cmd_wdata, 1'b0);
          else if (m_pend) begin
            model_start(1'b0, PA, PR, 16'h0000, 1'b1);
            m_started_poll = 1'b1;
          end
        end
        P_FRAME: begin
          if (m_t == FRAME_CYC - 1) begin
            m_phase = P_DONE;
            if (m_poll) begin
              m_link  = m_resp[10];
              m_speed = m_resp[15:14];
            end else if (!m_write) begin
              m_rdata = m_resp;
            end
          end else begin
            m_t++;
          end
        end
        default: m_phase = P_IDLE;
      endcase
      if (!poll_en) begin
        m_pcnt = 0;
        m_pend = 1'b0;
      end else begin
        m_pcnt = m_hit ? 0 : m_pcnt + 1;
        if (m_hit) m_pend = 1'b1;
        else if (m_started_poll) m_pend = 1'b0;
      end
    end
  end

  // PHY: drives read data for the whole bit period of each DATA bit.
  always @(negedge clk_sys) begin
    if (m_phase == P_FRAME && !m_write && (m_t / BIT_CYC) >= 48)
      mdio_i = m_resp[63 - (m_t / BIT_CYC)];
    else
      mdio_i = 1'b1;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk_sys) begin
    int   b;
    logic e_mdc, e_o, e_oe;
    e_mdc = 1'b0; e_o = 1'b1; e_oe = 1'b0;
    if (m_phase == P_FRAME) begin
      b     = m_t / BIT_CYC;
      e_mdc = (m_t % BIT_CYC) >= CD;
      e_oe  = m_oe[63 - b];
      e_o   = m_frame[63 - b];
    end
    chk("phy_reset_n", 64'(phy_reset_n), 64'(m_phase != P_HOLD));
    chk("cmd_ready",   64'(cmd_ready),   64'(m_phase == P_IDLE));
    chk("busy",        64'(busy),        64'(m_phase != P_IDLE));
    chk("mdc",         64'(mdc),         64'(e_mdc));
    chk("mdio_oe",     64'(mdio_oe),     64'(e_oe));
    if (m_phase != P_FRAME || e_oe) chk("mdio_o", 64'(mdio_o), 64'(e_o));
    chk("rsp_valid",   64'(rsp_valid),   64'(m_phase == P_DONE && !m_poll));
    chk("rsp_rdata",   64'(rsp_rdata),   64'(m_rdata));
    chk("link_up",     64'(link_up),     64'(m_link));
    chk("link_speed",  64'(link_speed),  64'(m_speed));
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic w, input logic [4:0] pa, input logic [4:0] ra,
                          input logic [15:0] wd);
    logic r;
    r = 1'b0;
    cmd_valid = 1'b1; cmd_write = w; cmd_phyad = pa; cmd_regad = ra; cmd_wdata = wd;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_sys);
      r = cmd_ready;
      @(posedge clk_sys);
      if (r) break;
    end
    chk("cmd_accept", 64'(r), 64'd1);
    #2;
    cmd_valid = 1'b0;
  endtask

  task automatic release_and_count(input string name);
    int n;
    n = 0;
    @(posedge clk_sys); #2;
    rst_n_sys = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk_sys); #1;
      n++;
      if (phy_reset_n) break;
    end
    chk(name, 64'(n), 64'(RC));
    chk("ready_after_hold", 64'(cmd_ready), 64'd1);
    #1;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (m_phase != P_IDLE && k < 3000) begin
      @(posedge clk_sys); #2;
      k++;
    end
    chk("wait_idle", 64'(m_phase == P_IDLE), 64'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] cap;
    logic        prev_mdc, got;
    int          n, ncap, noe, npulse;

    // Reset state
    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst_phy_reset_n", 64'(phy_reset_n), 64'd0);
    chk("rst_busy",        64'(busy),        64'd1);
    chk("rst_cmd_ready",   64'(cmd_ready),   64'd0);
    chk("rst_mdio_o",      64'(mdio_o),      64'd1);
    chk("rst_mdio_oe",     64'(mdio_oe),     64'd0);
    chk("rst_rsp_rdata",   64'(rsp_rdata),   64'd0);
    release_and_count("hold_cycles");

    // Directed write, full bit stream and latency
    send_cmd(1'b1, 5'd1, 5'd0, 16'h1140);
    cap = '0; ncap = 0; n = 0; prev_mdc = 1'b0; got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_sys);
      n++;
      if (mdc && !prev_mdc) begin
        cap = {cap[62:0], mdio_o};
        ncap++;
      end
      prev_mdc = mdc;
      if (rsp_valid) begin got = 1'b1; break; end
    end
    chk("wr_rsp_seen", 64'(got), 64'd1);
    chk("wr_latency",  64'(n), 64'(FRAME_CYC + 1));
    chk("wr_nbits",    64'(ncap), 64'd64);
    chk("wr_bits",     cap, 64'hFFFF_FFFF_5082_1140);
    chk("wr_rdata_kept", 64'(rsp_rdata), 64'd0);
    @(posedge clk_sys); #2;

    // Directed read of 16'h0022
    host_phy_val = 16'h0022;
    send_cmd(1'b0, 5'd1, 5'd2, 16'h0000);
    noe = 0; npulse = 0; got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_sys);
      if (mdio_oe) noe++;
      if (rsp_valid) begin
        npulse++;
        chk("rd_rdata", 64'(rsp_rdata), 64'h0022);
        got = 1'b1;
        break;
      end
    end
    repeat (4) begin
      @(negedge clk_sys);
      if (rsp_valid) npulse++;
    end
    chk("rd_oe_cycles", 64'(noe), 64'(46 * BIT_CYC));
    chk("rd_pulses",    64'(npulse), 64'd1);
    @(posedge clk_sys); #2;

    // Host command and pending poll collide in IDLE
    poll_phy_val = 16'h8400;
    poll_en = 1'b1;
    send_cmd(1'b1, 5'd2, 5'd4, 16'hA5A5);
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk_sys);
      got = rsp_valid;
    end
    chk("col_host1_done", 64'(got), 64'd1);
    #1;
    host_phy_val = 16'h1234;
    send_cmd(1'b0, 5'd2, 5'd5, 16'h0000);
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk_sys);
      got = rsp_valid;
    end
    chk("col_host2_done", 64'(got), 64'd1);
    chk("col_host2_rdata", 64'(rsp_rdata), 64'h1234);
    @(negedge clk_sys);
    chk("col_idle_gap", 64'(cmd_ready), 64'd1);
    @(negedge clk_sys);
    chk("col_poll_started", 64'(busy), 64'd1);
    npulse = 0;
    for (int i = 0; i < FRAME_CYC + 2; i++) begin
      @(negedge clk_sys);
      if (rsp_valid) npulse++;
    end
    chk("poll_no_rsp",     64'(npulse), 64'd0);
    chk("poll_link_up",    64'(link_up), 64'd1);
    chk("poll_link_speed", 64'(link_speed), 64'd2);
    @(posedge clk_sys); #2;

    // Randomized traffic
    for (int it = 0; it < 12; it++) begin
      poll_en      = 1'($urandom_range(0, 1));
      poll_phy_val = 16'($urandom);
      host_phy_val = 16'($urandom);
      send_cmd(1'($urandom_range(0, 1)), 5'($urandom), 5'($urandom), 16'($urandom));
      repeat ($urandom_range(0, 300)) @(posedge clk_sys);
      #2;
    end
    poll_en = 1'b0;
    wait_idle();

    // Reset asserted during DATA bit 7 of a write, mid mdc-high phase
    send_cmd(1'b1, 5'd6, 5'd9, 16'hFFFF);
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk_sys);
      got = (m_phase == P_FRAME) && (m_t == 55 * BIT_CYC + CD);
    end
    chk("mid_reached", 64'(got), 64'd1);
    chk("mid_pre_mdc", 64'(mdc), 64'd1);
    chk("mid_pre_oe",  64'(mdio_oe), 64'd1);
    #1;
    rst_n_sys = 1'b0;
    #1;
    chk("mid_rst_oe",        64'(mdio_oe), 64'd0);
    chk("mid_rst_mdc",       64'(mdc), 64'd0);
    chk("mid_rst_phy_reset", 64'(phy_reset_n), 64'd0);
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("mid_rst_ready",     64'(cmd_ready), 64'd0);
    repeat (2) @(posedge clk_sys);
    release_and_count("hold_cycles_again");
    npulse = 0;
    repeat (20) begin
      @(negedge clk_sys);
      if (rsp_valid) npulse++;
    end
    chk("mid_rst_no_rsp", 64'(npulse), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

  // Watchdog
  initial begin
    #5ms;
    n_checks++;
    n_err++;
    $display("FAIL watchdog: got timeout expected completion at %0t", $time);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
